// File: rtl/sram_ctrl_if.sv
// Core-side word request bus for the external SRAM bridge.
// The master issues requests; the controller (slave) returns read data, ack and busy.
interface sram_ctrl_if;
  logic        i_stb;
  logic        i_rw;
  logic [16:0] i_addr;
  logic [31:0] i_dtw;
  logic [3:0]  i_be;
  logic [31:0] o_dtr;
  logic        o_ack;
  logic        o_busy;

  modport master (
    output i_stb, i_rw, i_addr, i_dtw, i_be,
    input  o_dtr, o_ack, o_busy
  );

  modport slave (
    input  i_stb, i_rw, i_addr, i_dtw, i_be,
    output o_dtr, o_ack, o_busy
  );
endinterface

// File: rtl/sram_ctrl.sv
// Bridges one 32-bit word request into four byte-wide async SRAM cycles
// (SETUP, TWAIT x ACCESS, RECOVER per enabled byte); every output is registered.
module sram_ctrl #(
  parameter int TWAIT = 3
) (
  input  logic        clk,
  input  logic        rstn,
  sram_ctrl_if.slave  bus,
  output logic [16:0] sram_a,
  output logic [7:0]  sram_dq_o,
  input  logic [7:0]  sram_dq_i,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_ce2,
  output logic        sram_we_n,
  output logic        sram_oe_n
);

  localparam int WW = $clog2(TWAIT + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_ACCESS  = 3'd2;
  localparam logic [2:0] S_RECOVER = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]    r_state;
  logic [1:0]    r_idx;
  logic [WW-1:0] r_wait;
  logic          r_rw;
  logic [14:0]   r_addr;
  logic [31:0]   r_dtw;
  logic [3:0]    r_be;
  logic [31:0]   r_stage;

  logic [3:0]    w_firstBe;
  logic [2:0]    w_first;
  logic [2:0]    w_next;
  logic          w_enterSetup;
  logic [1:0]    w_setIdx;
  logic [14:0]   w_setAddr;
  logic [31:0]   w_setData;
  logic          w_setWrite;
  logic [7:0]    w_setByte;

  // Returns {found, index} of the lowest set mask bit at or above lo.
  function automatic logic [2:0] pickByte(input logic [3:0] mask, input logic [2:0] lo);
    logic [2:0] res;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= lo)) res = {1'b1, 2'(i)};
    end
    return res;
  endfunction

  assign w_firstBe = bus.i_rw ? bus.i_be : 4'hF;
  assign w_first   = pickByte(w_firstBe, 3'd0);
  assign w_next    = pickByte(r_be, {1'b0, r_idx} + 3'd1);

  always_comb begin
    w_enterSetup = 1'b0;
    w_setIdx     = r_idx;
    w_setAddr    = r_addr;
    w_setData    = r_dtw;
    w_setWrite   = r_rw;
    if (r_state == S_IDLE && bus.i_stb && w_first[2]) begin
      w_enterSetup = 1'b1;
      w_setIdx     = w_first[1:0];
      w_setAddr    = bus.i_addr[16:2];
      w_setData    = bus.i_dtw;
      w_setWrite   = bus.i_rw;
    end else if (r_state == S_RECOVER && w_next[2]) begin
      w_enterSetup = 1'b1;
      w_setIdx     = w_next[1:0];
    end
    w_setByte = w_setData[{w_setIdx, 3'b000} +: 8];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_idx      <= 2'd0;
      r_wait     <= '0;
      r_rw       <= 1'b0;
      r_addr     <= 15'd0;
      r_dtw      <= 32'd0;
      r_be       <= 4'd0;
      r_stage    <= 32'd0;
      sram_a     <= 17'd0;
      sram_dq_o  <= 8'd0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_ce2   <= 1'b0;
      sram_we_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      bus.o_dtr  <= 32'd0;
      bus.o_ack  <= 1'b0;
      bus.o_busy <= 1'b0;
    end else begin
      bus.o_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_stb) begin
            r_rw       <= bus.i_rw;
            r_addr     <= bus.i_addr[16:2];
            r_dtw      <= bus.i_dtw;
            r_be       <= w_firstBe;
            bus.o_busy <= 1'b1;
            if (!w_first[2]) begin
              r_state   <= S_DONE;
              bus.o_ack <= 1'b1;
            end
          end
        end
        S_SETUP: begin
          r_state <= S_ACCESS;
          r_wait  <= WW'(TWAIT - 1);
          if (r_rw) sram_we_n <= 1'b0;
          else      sram_oe_n <= 1'b0;
        end
        // Read data is sampled on the edge that closes the last strobe cycle.
        S_ACCESS: begin
          if (r_wait == '0) begin
            r_state   <= S_RECOVER;
            sram_we_n <= 1'b1;
            sram_oe_n <= 1'b1;
            if (!r_rw) r_stage[{r_idx, 3'b000} +: 8] <= sram_dq_i;
          end else begin
            r_wait <= r_wait - 1'b1;
          end
        end
        S_RECOVER: begin
          if (!w_next[2]) begin
            r_state    <= S_DONE;
            bus.o_ack  <= 1'b1;
            sram_ce_n  <= 1'b1;
            sram_ce2   <= 1'b0;
            sram_dq_oe <= 1'b0;
            if (!r_rw) bus.o_dtr <= r_stage;
          end
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          bus.o_busy <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_enterSetup) begin
        r_state    <= S_SETUP;
        r_idx      <= w_setIdx;
        sram_a     <= {w_setAddr, w_setIdx};
        sram_ce_n  <= 1'b0;
        sram_ce2   <= 1'b1;
        sram_we_n  <= 1'b1;
        sram_oe_n  <= 1'b1;
        sram_dq_oe <= w_setWrite;
        if (w_setWrite) sram_dq_o <= w_setByte;
      end
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: behavioural SRAM, word-level reference memory,
// pin protocol monitor, directed scenarios followed by randomized requests.
module tb_sram_ctrl;

  localparam int TWAIT = 3;

  logic        clk;
  logic        rstn;
  logic [16:0] sramA;
  logic [7:0]  sramDqO;
  logic [7:0]  sramDqI;
  logic        sramDqOe;
  logic        sramCeN;
  logic        sramCe2;
  logic        sramWeN;
  logic        sramOeN;

  sram_ctrl_if bus ();

  sram_ctrl #(.TWAIT(TWAIT)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus),
    .sram_a     (sramA),
    .sram_dq_o  (sramDqO),
    .sram_dq_i  (sramDqI),
    .sram_dq_oe (sramDqOe),
    .sram_ce_n  (sramCeN),
    .sram_ce2   (sramCe2),
    .sram_we_n  (sramWeN),
    .sram_oe_n  (sramOeN)
  );

  logic [7:0]  mem    [0:131071];
  logic [7:0]  refMem [0:131071];
  logic [25:0] writeLog [$];
  int          testsRun;
  int          failCount;
  logic        lastEdgeReset;
  logic [31:0] lastRead;
  logic [31:0] lastMask;

  // The SRAM drives its data pins only while selected with OE low and the pads released.
  assign sramDqI = (!sramCeN && sramCe2 && !sramOeN && !sramDqOe) ? mem[sramA] : 8'hEE;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
      else begin
        failCount++;
        $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
  endtask

  // One complete request: drive in an IDLE cycle, time the ack, check data and pin writes.
  task automatic applyStimulus(input logic rw, input logic [16:0] addr, input logic [31:0] dtw,
                               input logic [3:0] be, input logic [31:0] cmpMask);
    logic [3:0]  effBe;
    logic [14:0] wordIdx;
    logic [31:0] expRead;
    logic [25:0] entry;
    int          nBytes, expAck, ackCyc, cyc, logStart, nBusyBad, b;
    effBe    = rw ? be : 4'hF;
    nBytes   = $countones(effBe);
    expAck   = nBytes * (TWAIT + 2) + 1;
    wordIdx  = addr[16:2];
    logStart = writeLog.size();
    @(negedge clk);
    bus.i_stb  = 1'b1;
    bus.i_rw   = rw;
    bus.i_addr = addr;
    bus.i_dtw  = dtw;
    bus.i_be   = be;
    @(posedge clk);
    #1 bus.i_stb = 1'b0;
    cyc = 1;
    ackCyc = 0;
    nBusyBad = 0;
    while (ackCyc == 0 && cyc <= expAck + 8) begin
      if (bus.o_ack === 1'b1) ackCyc = cyc;
      else begin
        if (bus.o_busy !== 1'b1) nBusyBad++;
        @(posedge clk);
        #1 cyc++;
      end
    end
    checkOutput("ackCycle", ackCyc, expAck);
    checkOutput("busyBeforeAck", nBusyBad, 0);
    checkOutput("busyAtAck", {31'd0, bus.o_busy}, 32'd1);
    if (rw) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) refMem[{wordIdx, 2'(i)}] = dtw[8*i +: 8];
    end
    expRead = {refMem[{wordIdx, 2'd3}], refMem[{wordIdx, 2'd2}],
               refMem[{wordIdx, 2'd1}], refMem[{wordIdx, 2'd0}]};
    if (!rw) begin
      checkOutput("readData", bus.o_dtr & cmpMask, expRead & cmpMask);
      lastRead = expRead;
      lastMask = cmpMask;
    end else begin
      checkOutput("dtrHold", bus.o_dtr & lastMask, lastRead & lastMask);
    end
    checkOutput("writeCount", writeLog.size() - logStart, rw ? nBytes : 0);
    for (int k = logStart; k < writeLog.size(); k++) begin
      entry = writeLog[k];
      b = int'(entry[9:8]);
      checkOutput("writeWord", {17'd0, entry[24:10]}, {17'd0, wordIdx});
      checkOutput("writeEnabled", {31'd0, be[b]}, 32'd1);
      checkOutput("writeByte", {23'd0, entry[25], entry[7:0]}, {23'd0, 1'b1, dtw[8*b +: 8]});
    end
    @(posedge clk);
    #1;
    checkOutput("idleBusy", {31'd0, bus.o_busy}, 32'd0);
    checkOutput("idleAck", {31'd0, bus.o_ack}, 32'd0);
  endtask

  initial begin
    int          logStart;
    int          period;
    int          resetCycle;
    logic [25:0] entry;

    rstn          = 1'b0;
    bus.i_stb     = 1'b0;
    bus.i_rw      = 1'b0;
    bus.i_addr    = 17'd0;
    bus.i_dtw     = 32'd0;
    bus.i_be      = 4'd0;
    testsRun      = 0;
    failCount     = 0;
    lastRead      = 32'd0;
    lastMask      = 32'hFFFFFFFF;
    lastEdgeReset = 1'b1;
    for (int i = 0; i < 131072; i++) begin
      mem[i]    = 8'h00;
      refMem[i] = 8'h00;
    end

    fork
      forever begin
        @(posedge clk);
        lastEdgeReset = !rstn;
      end
      begin : pinMonitor
        logic        prevWe;
        logic [16:0] prevA;
        logic [7:0]  prevDq;
        int          lowCount;
        prevWe   = 1'b1;
        prevA    = 17'd0;
        prevDq   = 8'd0;
        lowCount = 0;
        forever begin
          @(negedge clk);
          // A byte lands in the array when WE rises with the chip still selected.
          if (prevWe === 1'b0 && sramWeN === 1'b1 && sramCeN === 1'b0) begin
            writeLog.push_back({sramDqOe, sramA, sramDqO});
            mem[sramA] = sramDqO;
          end
          if (lastEdgeReset) begin
            lowCount = 0;
          end else begin
            checkOutput("weOeExclusive", {31'd0, !sramWeN && !sramOeN}, 32'd0);
            checkOutput("dqOeWhileOe", {31'd0, sramDqOe && !sramOeN}, 32'd0);
            if (!sramWeN || !sramOeN)
              checkOutput("chipSelected", {30'd0, sramCeN, sramCe2}, 32'd1);
            if (prevWe === 1'b0 && sramWeN === 1'b0)
              checkOutput("stableDuringWe", {7'd0, sramA, sramDqO}, {7'd0, prevA, prevDq});
            if (prevWe === 1'b0 && sramWeN === 1'b1)
              checkOutput("weLowWidth", lowCount, TWAIT);
            if (sramWeN === 1'b0) lowCount++;
            else                  lowCount = 0;
          end
          prevWe = sramWeN;
          prevA  = sramA;
          prevDq = sramDqO;
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstCeN",  {31'd0, sramCeN},  32'd1);
    checkOutput("rstCe2",  {31'd0, sramCe2},  32'd0);
    checkOutput("rstWeN",  {31'd0, sramWeN},  32'd1);
    checkOutput("rstOeN",  {31'd0, sramOeN},  32'd1);
    checkOutput("rstDqOe", {31'd0, sramDqOe}, 32'd0);
    checkOutput("rstAddr", {15'd0, sramA},    32'd0);
    checkOutput("rstDqO",  {24'd0, sramDqO},  32'd0);
    checkOutput("rstDtr",  bus.o_dtr,         32'd0);
    checkOutput("rstAck",  {31'd0, bus.o_ack},  32'd0);
    checkOutput("rstBusy", {31'd0, bus.o_busy}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    $display("[TB] full-word write then read");
    applyStimulus(1'b1, 17'h00010, 32'hA5C30F11, 4'hF, 32'hFFFFFFFF);
    checkOutput("memBytes10", {mem[17'h13], mem[17'h12], mem[17'h11], mem[17'h10]}, 32'hA5C30F11);
    applyStimulus(1'b0, 17'h00010, $urandom, 4'h0, 32'hFFFFFFFF);
    checkOutput("readWord10", bus.o_dtr, 32'hA5C30F11);

    $display("[TB] byte masking");
    applyStimulus(1'b1, 17'h00020, 32'hFFFFFFFF, 4'hF, 32'hFFFFFFFF);
    applyStimulus(1'b1, 17'h00020, 32'h12345678, 4'b0101, 32'hFFFFFFFF);
    applyStimulus(1'b0, 17'h00020, 32'h0, 4'h0, 32'hFFFFFFFF);
    checkOutput("maskedRead", bus.o_dtr, 32'hFF34FF78);

    $display("[TB] write with no enabled bytes");
    applyStimulus(1'b1, 17'h00030, $urandom, 4'h0, 32'hFFFFFFFF);

    $display("[TB] busy rejection and back-to-back");
    period   = (TWAIT + 2) + 2;
    logStart = writeLog.size();
    for (int k = 0; k < 3 * period; k++) begin
      @(negedge clk);
      checkOutput("b2bBusy", {31'd0, bus.o_busy}, (k % period == 0) ? 32'd0 : 32'd1);
      checkOutput("b2bAck",  {31'd0, bus.o_ack},  (k % period == period - 1) ? 32'd1 : 32'd0);
      bus.i_stb  = 1'b1;
      bus.i_rw   = 1'b1;
      bus.i_be   = 4'b0001;
      bus.i_addr = 17'h00200 + 17'(4 * k);
      bus.i_dtw  = {24'h0, 8'h40 + 8'(k)};
    end
    @(negedge clk);
    checkOutput("b2bBusyEnd", {31'd0, bus.o_busy}, 32'd0);
    bus.i_stb = 1'b0;
    checkOutput("b2bWrites", writeLog.size() - logStart, 3);
    for (int j = 0; j < 3; j++) begin
      if (logStart + j < writeLog.size()) begin
        entry = writeLog[logStart + j];
        checkOutput("b2bAddr", {15'd0, entry[24:8]}, {15'd0, 17'h00200 + 17'(4 * j * period)});
        checkOutput("b2bData", {23'd0, entry[25], entry[7:0]}, {23'd0, 1'b1, 8'h40 + 8'(j * period)});
        refMem[17'h00200 + 17'(4 * j * period)] = 8'h40 + 8'(j * period);
      end
    end

    $display("[TB] reset during byte 2 write strobe");
    resetCycle = 2 * (TWAIT + 2) + 2;
    logStart   = writeLog.size();
    @(negedge clk);
    bus.i_stb  = 1'b1;
    bus.i_rw   = 1'b1;
    bus.i_addr = 17'h00040;
    bus.i_dtw  = 32'hDEADBEEF;
    bus.i_be   = 4'hF;
    @(posedge clk);
    #1 bus.i_stb = 1'b0;
    repeat (resetCycle - 1) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midRstCeN",  {31'd0, sramCeN},  32'd1);
    checkOutput("midRstWeN",  {31'd0, sramWeN},  32'd1);
    checkOutput("midRstDqOe", {31'd0, sramDqOe}, 32'd0);
    checkOutput("midRstBusy", {31'd0, bus.o_busy}, 32'd0);
    checkOutput("midRstAck",  {31'd0, bus.o_ack},  32'd0);
    checkOutput("midRstDtr",  bus.o_dtr, 32'd0);
    #1 rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      checkOutput("postRstAck", {31'd0, bus.o_ack}, 32'd0);
      checkOutput("postRstBusy", {31'd0, bus.o_busy}, 32'd0);
    end
    checkOutput("midRstWrites", writeLog.size() - logStart, 2);
    checkOutput("midRstBytes", {16'd0, mem[17'h41], mem[17'h40]}, 32'h0000BEEF);
    refMem[17'h40] = 8'hEF;
    refMem[17'h41] = 8'hBE;
    lastRead = 32'd0;
    lastMask = 32'hFFFFFFFF;
    applyStimulus(1'b0, 17'h00040, 32'h0, 4'hF, 32'hFF00FFFF);

    $display("[TB] top of memory");
    applyStimulus(1'b1, 17'h1FFFF, 32'h8BADF00D, 4'hF, 32'hFFFFFFFF);
    checkOutput("noWrapLow", {mem[17'h3], mem[17'h2], mem[17'h1], mem[17'h0]}, 32'd0);
    applyStimulus(1'b0, 17'h1FFFF, 32'h0, 4'h0, 32'hFFFFFFFF);
    checkOutput("topRead", bus.o_dtr, 32'h8BADF00D);

    $display("[TB] randomized requests");
    for (int w = 0; w < 16; w++)
      applyStimulus(1'b1, 17'h00100 + 17'(4 * w), $urandom, 4'hF, 32'hFFFFFFFF);
    for (int r = 0; r < 24; r++)
      applyStimulus(1'($urandom_range(0, 1)), 17'h00100 + 17'($urandom_range(0, 63)),
                    $urandom, 4'($urandom_range(0, 15)), 32'hFFFFFFFF);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
